// File: rtl/grid_figure_renderer.sv
`timescale 1ns/1ps
// ROWS x COLS grid painter with per-cell figures and a blinking/lockable cursor; rgb lags HCount/VCount by 2 clocks.
// One pixel per clock, never stalls; button pulses act on the next clock.
module grid_figure_renderer #(
   parameter int         H_ACTIVE     = 640,
   parameter int         V_ACTIVE     = 480,
   parameter int         COLS         = 3,
   parameter int         ROWS         = 3,
   parameter int         BORDER_W     = 3,
   parameter int         RADIUS       = 60,
   parameter logic [2:0] FIG_COLOR    = 3'b001,
   parameter logic [2:0] BORDER_COLOR = 3'b110,
   parameter logic [2:0] CURSOR_COLOR = 3'b100,
   parameter int         BLINK_FRAMES = 30
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [9:0] HCount,
   input  logic [9:0] VCount,
   input  logic       VideoOn,
   input  logic       BtnUp,
   input  logic       BtnDown,
   input  logic       BtnLeft,
   input  logic       BtnRight,
   input  logic       BtnSel,
   output logic [2:0] rgb,
   output logic [2:0] CurCol,
   output logic [2:0] CurRow,
   output logic       Locked
);

   localparam int CW     = H_ACTIVE / COLS;
   localparam int CH     = V_ACTIVE / ROWS;
   localparam int CX     = CW / 2;
   localparam int CY     = CH / 2;
   localparam int RECT_W = 3 * RADIUS / 2;
   localparam int RAD_SQ = RADIUS * RADIUS;

   logic [9:0]  col_raw, row_raw, lx, ly;
   logic [2:0]  col_c, row_c;
   logic [10:0] dx_c, dy_c;
   logic        border_c, frame_start;

   // Last column/row absorb the remainder of the integer divide.
   always_comb begin
      col_raw     = HCount / 10'(CW);
      row_raw     = VCount / 10'(CH);
      col_c       = (col_raw > 10'(COLS - 1)) ? 3'(COLS - 1) : col_raw[2:0];
      row_c       = (row_raw > 10'(ROWS - 1)) ? 3'(ROWS - 1) : row_raw[2:0];
      lx          = HCount - 10'(int'(col_c) * CW);
      ly          = VCount - 10'(int'(row_c) * CH);
      dx_c        = {1'b0, lx} - 11'(CX);
      dy_c        = {1'b0, ly} - 11'(CY);
      border_c    = ((col_c != 3'd0) && (lx < 10'(BORDER_W))) ||
                    ((row_c != 3'd0) && (ly < 10'(BORDER_W)));
      frame_start = (HCount == 10'd0) && (VCount == 10'd0);
   end

   logic [2:0]         s1_col, s1_row;
   logic signed [10:0] s1_dx, s1_dy;
   logic               s1_on, s1_border;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_col    <= 3'd0;
         s1_row    <= 3'd0;
         s1_dx     <= '0;
         s1_dy     <= '0;
         s1_on     <= 1'b0;
         s1_border <= 1'b0;
      end else begin
         s1_col    <= col_c;
         s1_row    <= row_c;
         s1_dx     <= dx_c;
         s1_dy     <= dy_c;
         s1_on     <= VideoOn;
         s1_border <= border_c;
      end
   end

   logic [10:0] adx, ady;
   logic [21:0] dist_sq;
   logic [1:0]  fig_type;
   logic        in_box, hit, is_cursor, blink_phase;

   always_comb begin
      adx       = s1_dx[10] ? (~s1_dx + 11'd1) : s1_dx;
      ady       = s1_dy[10] ? (~s1_dy + 11'd1) : s1_dy;
      dist_sq   = ({11'd0, adx} * {11'd0, adx}) + ({11'd0, ady} * {11'd0, ady});
      fig_type  = 2'((int'(s1_row) * COLS + int'(s1_col)) % 4);
      in_box    = (adx <= 11'(RADIUS)) && (ady <= 11'(RADIUS));
      hit       = 1'b0;
      case (fig_type)
         2'd0:    hit = in_box;
         2'd1:    hit = (adx <= 11'(RECT_W)) && (ady <= 11'(RADIUS));
         2'd2:    hit = in_box && (s1_dx <= s1_dy);
         default: hit = (dist_sq <= 22'(RAD_SQ));
      endcase
      is_cursor = (s1_row == CurRow) && (s1_col == CurCol) && (Locked || blink_phase);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       rgb <= 3'b000;
      else if (!s1_on)    rgb <= 3'b000;
      else if (hit)       rgb <= is_cursor ? CURSOR_COLOR : FIG_COLOR;
      else if (s1_border) rgb <= BORDER_COLOR;
      else                rgb <= 3'b000;
   end

   // Moves sample the pre-toggle Locked, so a move paired with BtnSel obeys the old lock state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         CurCol <= 3'd0;
         CurRow <= 3'd0;
         Locked <= 1'b0;
      end else begin
         if (!Locked) begin
            if (BtnLeft && !BtnRight)
               CurCol <= (CurCol == 3'd0) ? 3'(COLS - 1) : CurCol - 3'd1;
            else if (BtnRight && !BtnLeft)
               CurCol <= (CurCol == 3'(COLS - 1)) ? 3'd0 : CurCol + 3'd1;
            if (BtnUp && !BtnDown)
               CurRow <= (CurRow == 3'd0) ? 3'(ROWS - 1) : CurRow - 3'd1;
            else if (BtnDown && !BtnUp)
               CurRow <= (CurRow == 3'(ROWS - 1)) ? 3'd0 : CurRow + 3'd1;
         end
         if (BtnSel) Locked <= !Locked;
      end
   end

   logic [5:0] frame_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt   <= 6'd0;
         blink_phase <= 1'b0;
      end else if (frame_start) begin
         if (frame_cnt == 6'(BLINK_FRAMES - 1)) begin
            frame_cnt   <= 6'd0;
            blink_phase <= !blink_phase;
         end else begin
            frame_cnt   <= frame_cnt + 6'd1;
         end
      end
   end

endmodule

// File: tb/tb_grid_figure_renderer.sv
`timescale 1ns/1ps
// Directed bench for grid_figure_renderer (BLINK_FRAMES=2); frame starts occur only where a test drives (0,0).
module tb_grid_figure_renderer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [9:0] HCount, VCount;
   logic       VideoOn, BtnUp, BtnDown, BtnLeft, BtnRight, BtnSel;
   logic [2:0] rgb, CurCol, CurRow;
   logic       Locked;

   int ncmp = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   grid_figure_renderer #(.BLINK_FRAMES(2)) dut (
      .clk(clk), .reset_n(reset_n), .HCount(HCount), .VCount(VCount), .VideoOn(VideoOn),
      .BtnUp(BtnUp), .BtnDown(BtnDown), .BtnLeft(BtnLeft), .BtnRight(BtnRight), .BtnSel(BtnSel),
      .rgb(rgb), .CurCol(CurCol), .CurRow(CurRow), .Locked(Locked)
   );

   task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic on, output logic [2:0] got);
      @(negedge clk);
      HCount = h; VCount = v; VideoOn = on;
      repeat (2) @(posedge clk);
      #1 got = rgb;
      @(negedge clk);
      HCount = 10'd5; VCount = 10'd5; VideoOn = 1'b0;
   endtask

   task automatic pulse(input logic [4:0] b);
      @(negedge clk);
      {BtnUp, BtnDown, BtnLeft, BtnRight, BtnSel} = b;
      @(negedge clk);
      {BtnUp, BtnDown, BtnLeft, BtnRight, BtnSel} = 5'b0;
   endtask

   task automatic frame_start();
      @(negedge clk);
      HCount = 10'd0; VCount = 10'd0;
      @(negedge clk);
      HCount = 10'd5; VCount = 10'd5;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      HCount = 10'd5; VCount = 10'd5; VideoOn = 1'b0;
      {BtnUp, BtnDown, BtnLeft, BtnRight, BtnSel} = 5'b0;
      #12;
      ncmp++; if (rgb !== 3'b000) begin nfail++; $display("FAIL reset_rgb got=%b exp=000", rgb); end
      ncmp++; if (CurCol !== 3'd0) begin nfail++; $display("FAIL reset_curcol got=%0d exp=0", CurCol); end
      ncmp++; if (CurRow !== 3'd0) begin nfail++; $display("FAIL reset_currow got=%0d exp=0", CurRow); end
      ncmp++; if (Locked !== 1'b0) begin nfail++; $display("FAIL reset_locked got=%b exp=0", Locked); end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_shapes();
      logic [9:0] hs [9] = '{10'd320, 10'd409, 10'd410, 10'd320, 10'd522, 10'd542, 10'd148, 10'd149, 10'd639};
      logic [9:0] vs [9] = '{10'd80,  10'd80,  10'd80,  10'd141, 10'd90,  10'd70,  10'd282, 10'd283, 10'd80};
      logic [2:0] ex [9] = '{3'b001,  3'b001,  3'b000,  3'b000,  3'b001,  3'b000,  3'b001,  3'b000,  3'b000};
      logic [2:0] got;
      // Latency: one clock after presenting the pixel, rgb still reflects the idle pixel.
      @(negedge clk);
      HCount = 10'd320; VCount = 10'd80; VideoOn = 1'b1;
      @(posedge clk); #1;
      ncmp++; if (rgb !== 3'b000) begin nfail++; $display("FAIL latency_s1 got=%b exp=000", rgb); end
      @(posedge clk); #1;
      ncmp++; if (rgb !== 3'b001) begin nfail++; $display("FAIL latency_s2 got=%b exp=001", rgb); end
      @(negedge clk);
      HCount = 10'd5; VCount = 10'd5; VideoOn = 1'b0;
      for (int i = 0; i < 9; i++) begin
         pix(hs[i], vs[i], 1'b1, got);
         ncmp++;
         if (got !== ex[i]) begin
            nfail++; $display("FAIL shape%0d (%0d,%0d) got=%b exp=%b", i, hs[i], vs[i], got, ex[i]);
         end
      end
   endtask

   task automatic test_border();
      logic [9:0] hs [6] = '{10'd213, 10'd213, 10'd50,  10'd50,  10'd50,  10'd1};
      logic [9:0] vs [6] = '{10'd300, 10'd300, 10'd160, 10'd162, 10'd163, 10'd80};
      logic       on [6] = '{1'b1,    1'b0,    1'b1,    1'b1,    1'b1,    1'b1};
      logic [2:0] ex [6] = '{3'b110,  3'b000,  3'b110,  3'b110,  3'b000,  3'b000};
      logic [2:0] got;
      for (int i = 0; i < 6; i++) begin
         pix(hs[i], vs[i], on[i], got);
         ncmp++;
         if (got !== ex[i]) begin
            nfail++; $display("FAIL border%0d (%0d,%0d,on=%b) got=%b exp=%b", i, hs[i], vs[i], on[i], got, ex[i]);
         end
      end
   endtask

   task automatic test_lock();
      logic [2:0] got;
      pulse(5'b00001);
      ncmp++; if (Locked !== 1'b1) begin nfail++; $display("FAIL lock_set got=%b exp=1", Locked); end
      pix(10'd106, 10'd80, 1'b1, got);
      ncmp++; if (got !== 3'b100) begin nfail++; $display("FAIL lock_highlight got=%b exp=100", got); end
      pulse(5'b00010);
      ncmp++; if (CurCol !== 3'd0) begin nfail++; $display("FAIL lock_right got=%0d exp=0", CurCol); end
      pulse(5'b01000);
      ncmp++; if (CurRow !== 3'd0) begin nfail++; $display("FAIL lock_down got=%0d exp=0", CurRow); end
      pulse(5'b00001);
      ncmp++; if (Locked !== 1'b0) begin nfail++; $display("FAIL lock_clear got=%b exp=0", Locked); end
      pix(10'd106, 10'd80, 1'b1, got);
      ncmp++; if (got !== 3'b001) begin nfail++; $display("FAIL unlocked_phase0 got=%b exp=001", got); end
   endtask

   task automatic test_cursor_move();
      // Buttons packed as {up, down, left, right, sel}.
      logic [4:0] bt [11] = '{5'b00100, 5'b10000, 5'b00110, 5'b11000, 5'b00010, 5'b01000,
                              5'b10100, 5'b01010, 5'b00011, 5'b00101, 5'b00001};
      logic [2:0] ec [11] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd2, 3'd0, 3'd1, 3'd1, 3'd1};
      logic [2:0] er [11] = '{3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
      logic       el [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [2:0] got;
      for (int i = 0; i < 11; i++) begin
         pulse(bt[i]);
         ncmp++;
         if ({CurCol, CurRow, Locked} !== {ec[i], er[i], el[i]}) begin
            nfail++;
            $display("FAIL move%0d btn=%b got col=%0d row=%0d lock=%b exp col=%0d row=%0d lock=%b",
                     i, bt[i], CurCol, CurRow, Locked, ec[i], er[i], el[i]);
         end
      end
      pix(10'd320, 10'd80, 1'b1, got);
      ncmp++; if (got !== 3'b100) begin nfail++; $display("FAIL cursor_cell1 got=%b exp=100", got); end
      pix(10'd106, 10'd80, 1'b1, got);
      ncmp++; if (got !== 3'b001) begin nfail++; $display("FAIL noncursor_cell0 got=%b exp=001", got); end
      pulse(5'b00001);
      pulse(5'b00100);
      ncmp++;
      if ({CurCol, CurRow, Locked} !== {3'd0, 3'd0, 1'b0}) begin
         nfail++; $display("FAIL move_home got col=%0d row=%0d lock=%b exp col=0 row=0 lock=0", CurCol, CurRow, Locked);
      end
   endtask

   task automatic test_blink();
      logic [2:0] got;
      frame_start();
      pix(10'd106, 10'd80, 1'b1, got);
      ncmp++; if (got !== 3'b001) begin nfail++; $display("FAIL blink_1fs got=%b exp=001", got); end
      frame_start();
      pix(10'd106, 10'd80, 1'b1, got);
      ncmp++; if (got !== 3'b100) begin nfail++; $display("FAIL blink_2fs got=%b exp=100", got); end
      frame_start();
      frame_start();
      pix(10'd106, 10'd80, 1'b1, got);
      ncmp++; if (got !== 3'b001) begin nfail++; $display("FAIL blink_4fs got=%b exp=001", got); end
      frame_start();
      frame_start();
   endtask

   task automatic test_circle_edge();
      logic [2:0] got;
      pix(10'd167, 10'd80, 1'b1, got);
      ncmp++; if (got !== 3'b000) begin nfail++; $display("FAIL edge_dx61 got=%b exp=000", got); end
      pix(10'd166, 10'd80, 1'b1, got);
      ncmp++; if (got !== 3'b100) begin nfail++; $display("FAIL edge_dx60_phase1 got=%b exp=100", got); end
   endtask

   task automatic test_reset_mid();
      pulse(5'b01000);
      ncmp++; if (CurRow !== 3'd1) begin nfail++; $display("FAIL mid_down got=%0d exp=1", CurRow); end
      @(negedge clk);
      HCount = 10'd166; VCount = 10'd80; VideoOn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      ncmp++; if (rgb !== 3'b001) begin nfail++; $display("FAIL mid_before got=%b exp=001", rgb); end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      ncmp++; if (rgb !== 3'b000) begin nfail++; $display("FAIL mid_async_rgb got=%b exp=000", rgb); end
      ncmp++; if (CurRow !== 3'd0) begin nfail++; $display("FAIL mid_async_row got=%0d exp=0", CurRow); end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      ncmp++; if (rgb !== 3'b000) begin nfail++; $display("FAIL mid_release1 got=%b exp=000", rgb); end
      @(posedge clk); #1;
      ncmp++; if (rgb !== 3'b001) begin nfail++; $display("FAIL mid_release2 got=%b exp=001", rgb); end
      @(negedge clk);
      HCount = 10'd5; VCount = 10'd5; VideoOn = 1'b0;
   endtask

   initial begin
      test_reset();
      test_shapes();
      test_border();
      test_lock();
      test_cursor_move();
      test_blink();
      test_circle_edge();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
